radix2_divider: RTL and testbench
=================================

// Module: radix2_divider
// PURPOSE
//  Sequential radix-2 restoring integer divider for the RV32M DIV/DIVU/REM/REMU ops; inverse of the sequential Booth multiplier.
//  Sits in the ALU operations group beside the multiplier.
//  The ALU pulses start with two operands and reads quotient and remainder together when valid pulses.
//  Fixed latency, one result per operation, no pipelining.
// PARAMETERS
//  XLEN     default core_config_pkg::XLEN (32)   operand/result width
//  CNT_W    localparam $clog2(XLEN)+1            iteration counter width
// PORTS
//  clk        in   1     clock, all logic on rising edge
//  rst        in   1     synchronous reset, active-high
//  start      in   1     launch division; sampled only in IDLE
//  op_signed  in   1     1: both operands two's complement (DIV/REM); 0: unsigned
//  dividend   in   XLEN  numerator
//  divisor    in   XLEN  denominator
//  busy       out  1     high from the cycle after start is accepted until valid
//  valid      out  1     one-cycle pulse; quotient/remainder are final
//  quotient   out  XLEN  registered; holds until next accepted start
//  remainder  out  XLEN  registered; holds until next accepted start
// BEHAVIOUR
//  Reset (clk edge with rst=1): state=IDLE; busy, valid, quotient, remainder = 0. Overrides start.
//  States (div_state_t): IDLE -> CALC -> FIX -> IDLE.
//   IDLE: on start=1, latch the operand magnitudes into |a| and |b|.
//    Signed mode: negate negative operands; the magnitude of 0x80000000 is 0x80000000 unsigned.
//    Also latch neg_q = sa^sb and neg_r = sa; set count=0 and go to CALC.
//   CALC: one iteration per cycle, restoring, on an XLEN+1 bit partial remainder P.
//    P' = {P,a_msb} - b; if P' >= 0 shift in q bit 1 and keep P', else shift in 0 and restore.
//    Exactly XLEN cycles; go to FIX when count==XLEN-1.
//   FIX: negate the quotient if neg_q and the remainder if neg_r, then apply the special cases.
//    Register the outputs, set valid=1 for one cycle, busy=0, and return to IDLE.
//  Latency: start sampled at edge E0 -> valid high in the cycle after edge E(XLEN+2), i.e. 34 edges for RV32.
//  start while busy is ignored; no queueing. start in the same cycle valid is high is accepted (back-to-back ops).
//  Special cases, RISC-V defined, both modes:
//   divisor==0: quotient = all ones; remainder = dividend (unmodified).
//   op_signed & dividend==0x80000000 & divisor==0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
//  Sign rule: quotient truncates toward zero; remainder takes the sign of the dividend.
//  Operands are only captured in IDLE; input changes during CALC/FIX have no effect.
//  Reset mid-operation aborts: no valid pulse and outputs cleared.
// CONFIGURATION
//  DIV_FAST_PATH_EN defined:
//   Special cases are detected in IDLE and the FSM jumps straight to FIX.
//   valid is high in the cycle after edge E2, and busy is high for one cycle.
//   Normal cases are unchanged.
//  Undefined: every operation takes the full XLEN+2 edges; special-case results are still substituted in FIX.
//  Results are bit-identical in both builds; only latency differs.
// STRUCTURE
//  core_config_pkg gets div_state_t (IDLE/CALC/FIX, 2-bit enum) and localparam DIV_LATENCY = XLEN+2.
//  Sub-module div_step (combinational): inputs P, a_msb, b; outputs P_next and q_bit.
//   One restoring iteration, so the XLEN+1 bit subtract is isolated for timing.
//  Everything else (FSM, counter, sign fix, special muxing) stays in radix2_divider.
// TESTING
//  1 unsigned 100/7 -> q=14, r=2, valid exactly 34 edges after start, busy high for 33 cycles.
//  2 signed -7/2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); signed 7/-2 -> q=-3, r=1.
//  3 5/0 -> q=0xFFFFFFFF, r=5 in both modes; signed -5/0 -> q=0xFFFFFFFF, r=0xFFFFFFFB.
//  4 signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned same operands -> q=0, r=0x80000000.
//    Special-case latency is 34 edges without DIV_FAST_PATH_EN and 2 edges with it.
//  5 unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
//    Pulse start again at cycle 10 with new operands: ignored, and the result is unchanged.
//  6 Assert rst at cycle 15 of an operation: no valid pulse, outputs 0.
//    Then start 9/3 -> q=3, r=0. Issue back-to-back starts on the valid cycle: both results correct.

Source files
------------

// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the ALU operation blocks.
// Carries the datapath width and the sequential divider's state encoding.
package core_config_pkg;

    localparam int unsigned XLEN = 32;

    // Edges from start sampling to the valid pulse, counted inclusively
    // from the edge that launches start.
    localparam int unsigned DIV_LATENCY = XLEN + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/radix2_divider_div_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN:0]   p,
    input  logic            a_msb,
    input  logic [XLEN-1:0] b,
    output logic [XLEN:0]   p_next,
    output logic            q_bit
);

    logic [XLEN+1:0] shifted;
    logic [XLEN:0]   diff;

    // Trial subtract; the difference fits XLEN+1 bits whenever it is kept.
    always_comb begin
        shifted = {p, a_msb};
        q_bit   = (shifted >= {2'b00, b});
        diff    = shifted[XLEN:0] - {1'b0, b};
        p_next  = q_bit ? diff : shifted[XLEN:0];
    end

endmodule

// File: rtl/radix2_divider.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional build macro DIV_FAST_PATH_EN: divide-by-zero and signed overflow
// skip the iteration phase and finish two edges after start.
module radix2_divider
    import core_config_pkg::*;
#(
    parameter int unsigned XLEN = core_config_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            op_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state;
    logic [XLEN-1:0] a_sh;
    logic [XLEN-1:0] b_reg;
    logic [XLEN-1:0] q_sh;
    logic [XLEN:0]   p;
    logic [XLEN:0]   p_next;
    logic            q_bit;
    logic [CNT_W-1:0] count;
    logic            neg_q;
    logic            neg_r;
    logic            is_div0;
    logic            is_ovf;

    logic            sa;
    logic            sb;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            in_div0;
    logic            in_ovf;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    div_step #(.XLEN(XLEN)) u_step (
        .p      (p),
        .a_msb  (a_sh[XLEN-1]),
        .b      (b_reg),
        .p_next (p_next),
        .q_bit  (q_bit)
    );

    // Operand magnitudes, signs and special-case detection at the input.
    always_comb begin
        sa      = op_signed & dividend[XLEN-1];
        sb      = op_signed & divisor[XLEN-1];
        mag_a   = sa ? ('0 - dividend) : dividend;
        mag_b   = sb ? ('0 - divisor)  : divisor;
        in_div0 = (divisor == '0);
        in_ovf  = op_signed && (dividend == MIN_NEG) && (&divisor);
    end

    // Sign correction of the raw magnitude results.
    always_comb begin
        q_fix = neg_q ? ('0 - q_sh) : q_sh;
        r_fix = neg_r ? ('0 - p[XLEN-1:0]) : p[XLEN-1:0];
    end

    // Control FSM with the iteration datapath and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            valid     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            a_sh      <= '0;
            b_reg     <= '0;
            q_sh      <= '0;
            p         <= '0;
            count     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            is_div0   <= 1'b0;
            is_ovf    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= mag_a;
                        b_reg   <= mag_b;
                        q_sh    <= '0;
                        count   <= '0;
                        neg_q   <= sa ^ sb;
                        neg_r   <= sa;
                        is_div0 <= in_div0;
                        is_ovf  <= in_ovf;
                        busy    <= 1'b1;
`ifdef DIV_FAST_PATH_EN
                        // Skipping CALC: preload |a| so divide-by-zero
                        // leaves the same remainder the iterations would.
                        if (in_div0 || in_ovf) begin
                            p     <= {1'b0, mag_a};
                            state <= FIX;
                        end else begin
                            p     <= '0;
                            state <= CALC;
                        end
`else
                        p     <= '0;
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    p     <= p_next;
                    a_sh  <= {a_sh[XLEN-2:0], 1'b0};
                    q_sh  <= {q_sh[XLEN-2:0], q_bit};
                    count <= count + 1'b1;
                    if (count == CNT_W'(XLEN - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div0) begin
                        quotient  <= '1;
                        remainder <= r_fix;
                    end else if (is_ovf) begin
                        quotient  <= MIN_NEG;
                        remainder <= '0;
                    end else begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                    end
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_radix2_divider.sv
// Directed testbench for radix2_divider with hand-computed RV32M results.
module tb_radix2_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        valid;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_cmp;
    int n_bad;

    radix2_divider #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_signed (op_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .valid     (valid),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse in the current cycle (caller sits #1 after an edge).
    task automatic do_start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        op_signed = sgn;
        dividend  = a;
        divisor   = b;
    endtask

    // Wait for valid, scrambling the inputs after acceptance, then check the
    // latency, busy length and both results.
    task automatic await_result(input string tag, input logic [31:0] exp_q,
                                input logic [31:0] exp_r, input bit special,
                                input bit disturb);
        int  edges;
        int  busy_n;
        int  exp_lat;
        bit  got;
        edges  = 0;
        busy_n = 0;
        got    = 1'b0;
`ifdef DIV_FAST_PATH_EN
        exp_lat = special ? 2 : 34;
`else
        exp_lat = 34;
        if (special) exp_lat = 34;
`endif
        while (edges < 100 && !got) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) begin
                start     = 1'b0;
                dividend  = ~dividend;
                divisor   = divisor + 32'd3;
                op_signed = ~op_signed;
            end
            if (disturb && edges == 10) begin
                start     = 1'b1;
                op_signed = 1'b1;
                dividend  = 32'd7;
                divisor   = 32'd2;
            end
            if (disturb && edges == 11) start = 1'b0;
            if (valid) got = 1'b1;
            else if (busy) busy_n++;
        end
        check_eq({tag, "_valid_seen"}, 32'(got), 32'd1);
        check_eq({tag, "_latency"}, 32'(edges), 32'(exp_lat));
        check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
        check_eq({tag, "_q"}, quotient, exp_q);
        check_eq({tag, "_r"}, remainder, exp_r);
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input bit special, input bit disturb);
        @(posedge clk);
        #1;
        do_start(sgn, a, b);
        await_result(tag, exp_q, exp_r, special, disturb);
    endtask

    initial begin
        int vcount;
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        op_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset overrides start.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_q", quotient, 32'd0);
        check_eq("rst_r", remainder, 32'd0);
        rst = 1'b0;

        run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        // Valid is a single pulse; results hold afterwards.
        @(posedge clk);
        #1;
        check_eq("pulse_valid_low", 32'(valid), 32'd0);
        check_eq("hold_q", quotient, 32'd14);
        check_eq("hold_r", remainder, 32'd2);

        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
        run_op("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
        run_op("s5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
        run_op("s_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0);
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
        run_op("u_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
        run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);

        // Reset at cycle 15 of an operation aborts it.
        @(posedge clk);
        #1;
        do_start(1'b0, 32'd1000, 32'd3);
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_valid", 32'(valid), 32'd0);
        check_eq("abort_q", quotient, 32'd0);
        check_eq("abort_r", remainder, 32'd0);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid) vcount++;
        end
        check_eq("abort_no_valid", 32'(vcount), 32'd0);

        run_op("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);
        // Back-to-back: each start is issued in the cycle valid is high.
        do_start(1'b1, 32'hFFFF_FF9C, 32'd7);
        await_result("b2b_s_m100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_start(1'b0, 32'd1000, 32'd33);
        await_result("b2b_u1000_33", 32'd30, 32'd10, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
